// File: rtl/mems_pkg.sv
// Shared types and defaults for the MEMS beamformer sample sequencer.
package mems_pkg;

    localparam int N_CHAN_DEF     = 6;
    localparam int SAMPLE_W_DEF   = 16;
    localparam int DEPTH_LOG2_DEF = 8;
    localparam int CHAN_W         = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_LAST,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mic_delay_regs.sv
// Per-channel delay registers with a snapshot taken at frame start.
module mic_delay_regs
    import mems_pkg::*;
#(
    parameter int N_CHAN     = N_CHAN_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  cfg_we,
    input  logic [CHAN_W-1:0]     cfg_chan,
    input  logic [DEPTH_LOG2-1:0] cfg_delay,
    input  logic                  snap,
    input  logic [CHAN_W-1:0]     rd_chan,
    output logic [DEPTH_LOG2-1:0] rd_delay
);

    logic [DEPTH_LOG2-1:0] dly_q  [N_CHAN];
    logic [DEPTH_LOG2-1:0] snap_q [N_CHAN];
    logic                  cfg_ok;

    assign cfg_ok = cfg_we &&
        ({1'b0, cfg_chan} < (CHAN_W+1)'(N_CHAN));

    // Snapshot sees the pre-write value, so a same-cycle cfg applies next frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N_CHAN; i++) begin
                dly_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            if (cfg_ok)
                dly_q[cfg_chan] <= cfg_delay;
            if (snap) begin
                for (int i = 0; i < N_CHAN; i++)
                    snap_q[i] <= dly_q[i];
            end
        end
    end

    assign rd_delay = snap_q[rd_chan];

endmodule

// File: rtl/mic_delay_sched.sv
// Frame sequencer: writes mic history to shared RAM, reads delayed
// samples back and sums them into one beamformed output.
module mic_delay_sched
    import mems_pkg::*;
#(
    parameter int N_CHAN     = N_CHAN_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int SUM_W      = SAMPLE_W + 3
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         frame_stb,
    input  logic [N_CHAN*SAMPLE_W-1:0]   mic_data,
    input  logic                         cfg_we,
    input  logic [CHAN_W-1:0]            cfg_chan,
    input  logic [DEPTH_LOG2-1:0]        cfg_delay,
    output logic                         ram_we,
    output logic [DEPTH_LOG2+CHAN_W-1:0] ram_addr,
    output logic [SAMPLE_W-1:0]          ram_wdata,
    input  logic [SAMPLE_W-1:0]          ram_rdata,
    output logic [SUM_W-1:0]             sum_out,
    output logic                         sum_valid,
    output logic                         busy,
    output logic                         overrun
);

    state_e                state_q, state_d;
    logic [CHAN_W-1:0]     chan_q;
    logic [DEPTH_LOG2-1:0] wr_frame_q;
    logic [SAMPLE_W-1:0]   smp_q [N_CHAN];
    logic [SUM_W-1:0]      acc_q;
    logic [SUM_W-1:0]      sum_q;
    logic                  overrun_q;
    logic [DEPTH_LOG2-1:0] rd_delay;
    logic [SUM_W-1:0]      rdata_ext;
    logic [SUM_W-1:0]      acc_next;
    logic                  last_chan;
    logic                  snap;

    assign last_chan = (chan_q == CHAN_W'(N_CHAN - 1));
    assign snap      = (state_q == ST_IDLE) && frame_stb;
    assign rdata_ext = {{(SUM_W-SAMPLE_W){ram_rdata[SAMPLE_W-1]}},
                        ram_rdata};
    assign acc_next  = acc_q + rdata_ext;

    mic_delay_regs #(
        .N_CHAN     (N_CHAN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_regs (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cfg_we    (cfg_we),
        .cfg_chan  (cfg_chan),
        .cfg_delay (cfg_delay),
        .snap      (snap),
        .rd_chan   (chan_q),
        .rd_delay  (rd_delay)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_stb)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                ram_addr  = {wr_frame_q, chan_q};
                ram_wdata = smp_q[chan_q];
                if (last_chan)
                    state_d = ST_READ;
            end
            ST_READ: begin
                // Unsigned subtraction gives the modulo-depth wrap.
                ram_addr = {wr_frame_q - rd_delay, chan_q};
                if (last_chan)
                    state_d = ST_LAST;
            end
            ST_LAST: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chan_q     <= '0;
            wr_frame_q <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            overrun_q  <= 1'b0;
            for (int i = 0; i < N_CHAN; i++)
                smp_q[i] <= '0;
        end else begin
            if (frame_stb && state_q != ST_IDLE)
                overrun_q <= 1'b1;
            if (snap) begin
                for (int i = 0; i < N_CHAN; i++)
                    smp_q[i] <= mic_data[i*SAMPLE_W +: SAMPLE_W];
            end
            if (state_q == ST_WRITE || state_q == ST_READ)
                chan_q <= last_chan ? '0 : chan_q + 1'b1;
            else
                chan_q <= '0;
            // rdata lags the address by one cycle: read c lands during c+1.
            if (state_q == ST_READ)
                acc_q <= (chan_q == '0) ? '0 : acc_next;
            if (state_q == ST_LAST) begin
                acc_q <= acc_next;
                sum_q <= acc_next;
            end
            if (state_q == ST_DONE)
                wr_frame_q <= wr_frame_q + 1'b1;
        end
    end

    assign sum_out   = sum_q;
    assign sum_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mic_delay_sched.sv
// Directed bench for mic_delay_sched with a 1-cycle RAM and a history model.
module tb_mic_delay_sched;

    localparam int NC = 6;
    localparam int SW = 16;
    localparam int DL = 8;
    localparam int SUMW = SW + 3;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            frame_stb = 1'b0;
    logic [NC*SW-1:0] mic_data = '0;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_chan = '0;
    logic [DL-1:0]   cfg_delay = '0;
    logic            ram_we;
    logic [DL+2:0]   ram_addr;
    logic [SW-1:0]   ram_wdata;
    logic [SW-1:0]   ram_rdata;
    logic [SUMW-1:0] sum_out;
    logic            sum_valid;
    logic            busy;
    logic            overrun;

    mic_delay_sched dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .frame_stb (frame_stb),
        .mic_data  (mic_data),
        .cfg_we    (cfg_we),
        .cfg_chan  (cfg_chan),
        .cfg_delay (cfg_delay),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    logic [SW-1:0] ram [2048];
    logic          ram_clr = 1'b1;

    always @(posedge CLK) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++)
                ram[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            ram_rdata <= ram[ram_addr];
        end
    end

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [SW-1:0]   ref_mem [2048];
    logic [DL-1:0]   mdly [NC];
    logic [DL-1:0]   wf_m = '0;
    logic [SW-1:0]   cur [NC];
    logic [SUMW-1:0] exp_sum;
    logic            seen_sv;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic set_delay(input int c, input int d);
        cfg_we    = 1'b1;
        cfg_chan  = 3'(c);
        cfg_delay = DL'(d);
        tick();
        cfg_we = 1'b0;
        if (c < NC)
            mdly[c] = DL'(d);
    endtask

    function automatic logic [SUMW-1:0] model_sum();
        int s = 0;
        logic [DL-1:0] fr;
        for (int c = 0; c < NC; c++) begin
            fr = wf_m - mdly[c];
            s += int'($signed(ref_mem[{fr, 3'(c)}]));
        end
        return SUMW'(s);
    endfunction

    // Assumes the DUT is idle at the current negedge.
    task automatic start_frame(input logic [SW-1:0] s [NC]);
        for (int c = 0; c < NC; c++) begin
            cur[c] = s[c];
            mic_data[c*SW +: SW] = s[c];
            ref_mem[{wf_m, 3'(c)}] = s[c];
        end
        exp_sum = model_sum();
        frame_stb = 1'b1;
        cyc = 0;
        tick();
        frame_stb = 1'b0;
    endtask

    task automatic finish_frame(input bit chk_wr, input bit use_hand,
                                input logic [SUMW-1:0] hand);
        while (!sum_valid && cyc < 30) begin
            if (chk_wr && cyc >= 1 && cyc <= NC)
                chk($sformatf("write%0d", cyc - 1),
                    32'({ram_we, ram_addr, ram_wdata}),
                    32'({1'b1, wf_m, 3'(cyc - 1), cur[cyc-1]}));
            tick();
        end
        chk("latency", 32'(cyc), 32'(2*NC + 2));
        chk("sum", 32'(sum_out), 32'(use_hand ? hand : exp_sum));
        wf_m = wf_m + 1'b1;
        tick();
        chk("sv_pulse", 32'(sum_valid), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            ref_mem[i] = '0;
        for (int c = 0; c < NC; c++)
            mdly[c] = '0;

        // Reset state
        tick();
        tick();
        ram_clr = 1'b0;
        chk("rst_we", 32'(ram_we), 32'(0));
        chk("rst_addr", 32'(ram_addr), 32'(0));
        chk("rst_wdata", 32'(ram_wdata), 32'(0));
        chk("rst_sum", 32'(sum_out), 32'(0));
        chk("rst_flags", 32'({sum_valid, busy, overrun}), 32'(0));
        RST_N = 1'b1;
        tick();

        // 1: delays 0, samples 1..6
        start_frame('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
        chk("busy", 32'(busy), 32'(1));
        finish_frame(1'b1, 1'b1, SUMW'(21));

        // 2: delays 1, constant frames
        for (int c = 0; c < NC; c++)
            set_delay(c, 1);
        start_frame('{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1});
        finish_frame(1'b0, 1'b1, SUMW'(21));
        start_frame('{16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2});
        finish_frame(1'b0, 1'b1, SUMW'(6));
        start_frame('{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3});
        finish_frame(1'b0, 1'b1, SUMW'(12));

        // 3: wrap, chan0 delay 255
        set_delay(0, 255);
        for (int c = 1; c < NC; c++)
            set_delay(c, 0);
        for (int f = 0; f < 300; f++) begin
            for (int c = 0; c < NC; c++)
                cur[c] = SW'(f * 37 + c * 1000 - 3000);
            start_frame(cur);
            finish_frame(1'b0, 1'b0, '0);
        end

        // 4: full negative scale
        set_delay(0, 0);
        start_frame('{16'h8000, 16'h8000, 16'h8000,
                      16'h8000, 16'h8000, 16'h8000});
        finish_frame(1'b0, 1'b1, SUMW'(-196608));

        // 5: overrun, dropped frame
        chk("ovr_before", 32'(overrun), 32'(0));
        start_frame('{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60});
        while (cyc < 5)
            tick();
        mic_data = {NC{16'h7fff}};
        frame_stb = 1'b1;
        tick();
        frame_stb = 1'b0;
        chk("ovr_set", 32'(overrun), 32'(1));
        finish_frame(1'b0, 1'b1, SUMW'(210));
        start_frame('{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6});
        finish_frame(1'b1, 1'b1, SUMW'(21));
        chk("ovr_sticky", 32'(overrun), 32'(1));

        // 6: cfg mid-READ uses snapshot, then reset mid-WRITE
        set_delay(2, 1);
        set_delay(6, 9);
        start_frame('{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600});
        finish_frame(1'b0, 1'b1, SUMW'(100+200+3+400+500+600));
        start_frame('{16'd1000, 16'd1001, 16'd1002,
                      16'd1003, 16'd1004, 16'd1005});
        while (cyc < NC + 3)
            tick();
        cfg_we = 1'b1;
        cfg_chan = 3'd2;
        cfg_delay = '0;
        tick();
        cfg_we = 1'b0;
        finish_frame(1'b0, 1'b1, SUMW'(1000+1001+300+1003+1004+1005));
        mdly[2] = '0;

        start_frame('{16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9});
        while (cyc < 3)
            tick();
        RST_N = 1'b0;
        tick();
        chk("arst_we", 32'(ram_we), 32'(0));
        chk("arst_addr", 32'(ram_addr), 32'(0));
        chk("arst_wdata", 32'(ram_wdata), 32'(0));
        chk("arst_sum", 32'(sum_out), 32'(0));
        chk("arst_flags", 32'({sum_valid, busy, overrun}), 32'(0));
        RST_N = 1'b1;
        seen_sv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sum_valid)
                seen_sv = 1'b1;
            tick();
        end
        chk("no_partial_sv", 32'(seen_sv), 32'(0));
        wf_m = '0;
        for (int c = 0; c < NC; c++)
            mdly[c] = '0;
        start_frame('{16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12});
        finish_frame(1'b1, 1'b1, SUMW'(57));
        chk("ovr_clear", 32'(overrun), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
